laserdrop_word_queue: RTL and testbench

- Byte-to-word FIFO on the LaserDrop receive path; the opposite direction of the 16-bit-in / 8-bit-out transmit queue.
- Accepts one received laser byte per cycle from the receiver front end.
- Presents little-endian 16-bit words (first byte received in [7:0]) to the host-side writer.
- Handles a trailing odd byte at end of transfer through a pad-and-flush mechanism.

---
 rtl/laserdrop_pkg.sv | 20 ++
 rtl/laserdrop_word_queue.sv | 106 ++++++++++
 tb/tb_laserdrop_word_queue.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/laserdrop_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : laserdrop_pkg
// Description : Shared types and constants for the LaserDrop byte/word queues.
// Revision    : 1.0 - initial release
// ============================================================================
package laserdrop_pkg;

  typedef logic [7:0]  byte_t;
  typedef logic [15:0] word_t;

  // Default byte capacity of the receive word queue (power of 2, >= 4).
  localparam int    QUEUE_DEPTH = 64;

  // Filler placed in the upper byte when a lone trailing byte is flushed.
  localparam byte_t PAD_BYTE    = 8'h00;

endpackage : laserdrop_pkg
`default_nettype wire

// File: rtl/laserdrop_word_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : laserdrop_word_queue
// Description : Receive-path byte-in / little-endian word-out FIFO with a
//               fall-through head, pad-and-flush of an odd trailing byte and
//               a sticky overrun flag for dropped loads.
// Revision    : 1.0 - initial release
// ============================================================================
module laserdrop_word_queue
  import laserdrop_pkg::*;
#(
  parameter int    DEPTH = QUEUE_DEPTH,
  parameter byte_t PAD   = PAD_BYTE
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   clear,
  input  byte_t                  D,
  input  logic                   load,
  input  logic                   flush,
  input  logic                   read,
  output word_t                  Q,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] size,
  output logic                   empty,
  output logic                   full,
  output logic                   overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = AW + 1;

  byte_t         mem [DEPTH];
  logic [AW-1:0] read_i;
  logic [AW-1:0] write_i;
  logic [AW-1:0] read_n;
  logic          head_ok;
  logic          tail_ok;
  logic          rd_ok;
  logic          ld_ok;
  logic [1:0]    pop_cnt;
  logic [SW-1:0] size_next;

  // Second byte of the head word; wraps naturally with the pointer width.
  assign read_n  = read_i + AW'(1);

  assign empty   = (size == '0);
  assign full    = (size == SW'(DEPTH));

  // A full word is available, or a lone byte is released by flush.
  assign head_ok = (size >= SW'(2));
  assign tail_ok = (size == SW'(1)) && flush;
  assign valid   = head_ok || tail_ok;

  // Fall-through head word; forced to zero when nothing is poppable so the
  // output never exposes unwritten storage.
  always_comb begin
    Q = '0;
    if (head_ok) begin
      Q = {mem[read_n], mem[read_i]};
    end else if (tail_ok) begin
      Q = {PAD, mem[read_i]};
    end
  end

  assign rd_ok     = read && valid;
  assign pop_cnt   = !rd_ok ? 2'd0 : (head_ok ? 2'd2 : 2'd1);
  // A pop in the same cycle frees room, so a load at full still lands.
  assign ld_ok     = load && (!full || rd_ok);
  // Never exceeds DEPTH: a load at full is only accepted alongside a pop.
  assign size_next = size + SW'(ld_ok) - SW'(pop_cnt);

  // Pointer, occupancy and overrun tracking; clear overrides load/read.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      read_i  <= '0;
      write_i <= '0;
      size    <= '0;
      overrun <= 1'b0;
    end else if (clear) begin
      read_i  <= '0;
      write_i <= '0;
      size    <= '0;
      overrun <= 1'b0;
    end else begin
      read_i <= read_i + AW'(pop_cnt);
      if (ld_ok) begin
        write_i <= write_i + AW'(1);
      end
      size <= size_next;
      if (load && !ld_ok) begin
        overrun <= 1'b1;
      end
    end
  end

  // Byte storage; contents are intentionally left unreset.
  always_ff @(posedge clock) begin
    if (ld_ok && !clear) begin
      mem[write_i] <= D;
    end
  end

endmodule : laserdrop_word_queue
`default_nettype wire

// File: tb/tb_laserdrop_word_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_laserdrop_word_queue
// Description : Directed self-checking bench for laserdrop_word_queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_laserdrop_word_queue;
  import laserdrop_pkg::*;

  localparam int DEPTH = 64;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic       clear   = 1'b0;
  logic       load    = 1'b0;
  logic       flush   = 1'b0;
  logic       read    = 1'b0;
  byte_t      D       = '0;
  word_t      Q;
  logic       valid;
  logic       empty;
  logic       full;
  logic       overrun;
  logic [6:0] size;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  laserdrop_word_queue #(.DEPTH(DEPTH), .PAD(8'h00)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (clear),
    .D       (D),
    .load    (load),
    .flush   (flush),
    .read    (read),
    .Q       (Q),
    .valid   (valid),
    .size    (size),
    .empty   (empty),
    .full    (full),
    .overrun (overrun)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    #12;
    n_checks++; if (size !== 7'd0) begin n_fail++; $display("FAIL reset_size: got %0d expected 0", size); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", full); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    n_checks++; if ((^Q) === 1'bx) begin n_fail++; $display("FAIL reset_q_known: got %h expected no X", Q); end
    @(negedge clock);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_pair();
    load = 1'b1; D = 8'hA1;
    tick();
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL pair_valid_1: got %b expected 0", valid); end
    n_checks++; if (size !== 7'd1) begin n_fail++; $display("FAIL pair_size_1: got %0d expected 1", size); end
    D = 8'hB2;
    tick();
    load = 1'b0;
    n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL pair_valid_2: got %b expected 1", valid); end
    n_checks++; if (Q !== 16'hB2A1) begin n_fail++; $display("FAIL pair_q: got %h expected b2a1", Q); end
    n_checks++; if (size !== 7'd2) begin n_fail++; $display("FAIL pair_size_2: got %0d expected 2", size); end
    read = 1'b1;
    tick();
    read = 1'b0;
    n_checks++; if (size !== 7'd0) begin n_fail++; $display("FAIL pair_size_0: got %0d expected 0", size); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL pair_empty: got %b expected 1", empty); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL pair_valid_0: got %b expected 0", valid); end
  endtask

  task automatic test_odd_flush();
    load = 1'b1;
    D = 8'h11; tick();
    D = 8'h22; tick();
    D = 8'h33; tick();
    load = 1'b0;
    n_checks++; if (Q !== 16'h2211) begin n_fail++; $display("FAIL odd_q_head: got %h expected 2211", Q); end
    read = 1'b1; tick(); read = 1'b0;
    n_checks++; if (size !== 7'd1) begin n_fail++; $display("FAIL odd_size_1: got %0d expected 1", size); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL odd_valid_noflush: got %b expected 0", valid); end
    // A read with nothing poppable must be ignored.
    read = 1'b1; tick(); read = 1'b0;
    n_checks++; if (size !== 7'd1) begin n_fail++; $display("FAIL odd_ignored_read: got %0d expected 1", size); end
    flush = 1'b1;
    #1;
    n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL odd_valid_flush: got %b expected 1", valid); end
    n_checks++; if (Q !== 16'h0033) begin n_fail++; $display("FAIL odd_q_pad: got %h expected 0033", Q); end
    read = 1'b1; tick(); read = 1'b0; flush = 1'b0;
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL odd_empty: got %b expected 1", empty); end
  endtask

  task automatic test_full_overrun();
    word_t exp;
    load = 1'b1;
    for (int i = 0; i < 64; i++) begin
      D = 8'(i);
      tick();
    end
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_flag: got %b expected 1", full); end
    n_checks++; if (size !== 7'd64) begin n_fail++; $display("FAIL full_size: got %0d expected 64", size); end
    D = 8'hFF;
    tick();
    load = 1'b0;
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b expected 1", overrun); end
    n_checks++; if (size !== 7'd64) begin n_fail++; $display("FAIL ovr_size: got %0d expected 64", size); end
    n_checks++; if (Q !== 16'h0100) begin n_fail++; $display("FAIL ovr_q_first: got %h expected 0100", Q); end
    // Load at full together with a pop: both take effect.
    load = 1'b1; D = 8'h77; read = 1'b1;
    tick();
    load = 1'b0;
    n_checks++; if (size !== 7'd63) begin n_fail++; $display("FAIL simul_size: got %0d expected 63", size); end
    for (int i = 1; i < 32; i++) begin
      exp = {8'(2 * i + 1), 8'(2 * i)};
      n_checks++; if (Q !== exp) begin n_fail++; $display("FAIL drain_q[%0d]: got %h expected %h", i, Q, exp); end
      tick();
    end
    read = 1'b0;
    n_checks++; if (size !== 7'd1) begin n_fail++; $display("FAIL drain_size: got %0d expected 1", size); end
    flush = 1'b1;
    #1;
    n_checks++; if (Q !== 16'h0077) begin n_fail++; $display("FAIL simul_tail: got %h expected 0077", Q); end
    read = 1'b1; tick(); read = 1'b0; flush = 1'b0;
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b expected 1", empty); end
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
  endtask

  task automatic test_stream();
    byte_t model[$];
    int    sent  = 0;
    int    words = 0;
    int    cyc   = 0;
    bit    ld;
    bit    rd;
    word_t exp;
    clear = 1'b1; tick(); clear = 1'b0;
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL stream_clear_ovr: got %b expected 0", overrun); end
    while ((sent < 200 || model.size() > 0) && cyc < 3000) begin
      ld   = (sent < 200) && ($urandom_range(0, 3) != 0);
      rd   = ($urandom_range(0, 2) != 0);
      load = ld;
      read = rd;
      D    = 8'(sent) ^ 8'h5A;
      n_checks++;
      if (valid !== (model.size() >= 2)) begin
        n_fail++; $display("FAIL stream_valid: got %b expected %b at cycle %0d", valid, (model.size() >= 2), cyc);
      end
      if (rd && model.size() >= 2) begin
        exp = {model[1], model[0]};
        n_checks++; if (Q !== exp) begin n_fail++; $display("FAIL stream_q[%0d]: got %h expected %h", words, Q, exp); end
        void'(model.pop_front());
        void'(model.pop_front());
        words++;
      end
      if (ld && model.size() < DEPTH) begin
        model.push_back(D);
        sent++;
      end
      tick();
      cyc++;
    end
    load = 1'b0; read = 1'b0;
    n_checks++; if (cyc >= 3000) begin n_fail++; $display("FAIL stream_timeout: got %0d cycles expected under 3000", cyc); end
    n_checks++; if (words !== 100) begin n_fail++; $display("FAIL stream_words: got %0d expected 100", words); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL stream_ovr: got %b expected 0", overrun); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL stream_empty: got %b expected 1", empty); end
  endtask

  task automatic test_async_reset();
    load = 1'b1;
    for (int i = 0; i < 37; i++) begin
      D = 8'(i + 64);
      tick();
    end
    load = 1'b0;
    n_checks++; if (size !== 7'd37) begin n_fail++; $display("FAIL arst_pre_size: got %0d expected 37", size); end
    #3 reset_n = 1'b0;
    #1;
    n_checks++; if (size !== 7'd0) begin n_fail++; $display("FAIL arst_size: got %0d expected 0", size); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL arst_empty: got %b expected 1", empty); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b expected 0", valid); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL arst_ovr: got %b expected 0", overrun); end
    #2 reset_n = 1'b1;
    tick();
    load = 1'b1;
    D = 8'hC3; tick();
    D = 8'hD4; tick();
    load = 1'b0;
    n_checks++; if (Q !== 16'hD4C3) begin n_fail++; $display("FAIL arst_after_q: got %h expected d4c3", Q); end
    read = 1'b1; tick(); read = 1'b0;
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL arst_after_empty: got %b expected 1", empty); end
  endtask

  task automatic test_clear();
    load = 1'b1;
    for (int i = 0; i < 37; i++) begin
      D = 8'(i + 128);
      tick();
    end
    n_checks++; if (size !== 7'd37) begin n_fail++; $display("FAIL clr_pre_size: got %0d expected 37", size); end
    // Clear wins over a simultaneous load.
    clear = 1'b1; D = 8'hEE;
    tick();
    clear = 1'b0; load = 1'b0;
    n_checks++; if (size !== 7'd0) begin n_fail++; $display("FAIL clr_size: got %0d expected 0", size); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL clr_empty: got %b expected 1", empty); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL clr_valid: got %b expected 0", valid); end
    load = 1'b1;
    D = 8'hC5; tick();
    D = 8'hD6; tick();
    load = 1'b0;
    n_checks++; if (Q !== 16'hD6C5) begin n_fail++; $display("FAIL clr_after_q: got %h expected d6c5", Q); end
    read = 1'b1; tick(); read = 1'b0;
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL clr_after_empty: got %b expected 1", empty); end
  endtask

  initial begin
    test_reset();
    test_pair();
    test_odd_flush();
    test_full_overrun();
    test_stream();
    test_async_reset();
    test_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_laserdrop_word_queue
`default_nettype wire
